tile_shift_mesh: RTL and testbench
==================================

# tile_shift_mesh

Parametrised data-movement fabric for a compute tile: a TILE_DIM x TILE_DIM array of DATA_W-bit cell registers that shifts whole rows or columns in one of four directions for a programmed number of cycles. It extends the fixed 8-bit, 4-neighbour tile exchange with:
- generic lane width;
- selectable boundary modes (edge-in, wrap, zero-fill);
- a step counter with a start/busy/done handshake.

It sits between the tile controller and neighbouring tiles' edge ports. Host-side random access is provided for load and readback.

## Interface
- TILE_DIM, 2, cells per row and per column (>=2)
- DATA_W, 8, bits per cell
- CNT_W, 8, width of the step counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  starts a shift run when IDLE
- dir  in  2  shift direction: 0 EAST, 1 WEST, 2 SOUTH, 3 NORTH; sampled on start
- mode  in  2  boundary mode: 0 EDGE_IN, 1 WRAP, 2 ZERO, 3 reserved (treated as ZERO); sampled on start
- steps  in  CNT_W  number of shift cycles; sampled on start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- load_en  in  1  write load_data into cell (load_row, load_col)
- load_row, load_col  in  $clog2(TILE_DIM) each  write address
- load_data  in  DATA_W  write data
- rd_row, rd_col  in  $clog2(TILE_DIM) each  read address
- rd_data  out  DATA_W  registered read data
- WIN, EIN  in  TILE_DIM*DATA_W  west/east edge inputs; lane r = row r at bits [r*DATA_W +: DATA_W]
- NIN, SIN  in  TILE_DIM*DATA_W  north/south edge inputs; lane c = column c
- WOUT, EOUT  out  TILE_DIM*DATA_W  column 0 and column TILE_DIM-1 cell values, lane r = row r
- NOUT, SOUT  out  TILE_DIM*DATA_W  row 0 and row TILE_DIM-1 cell values, lane c = column c

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - start=1 latches dir, mode and steps.
  - steps!=0 → SHIFT, with the counter loaded to steps.
  - steps==0 → DONE directly; no cell changes.
- **SHIFT:**
  - Every cycle all cells move one position in the latched direction, and the counter decrements.
  - The last shift happens on the cycle where counter==1; that cycle then goes → DONE.
- **DONE:** done=1 for one cycle → IDLE.
- **EAST move:** cell[r][c] <= cell[r][c-1]. Column 0 takes:
  - EDGE_IN: WIN lane r;
  - WRAP: cell[r][TILE_DIM-1];
  - ZERO: 0.
- **Other directions** are symmetric:
  - WEST uses EIN / column 0;
  - SOUTH uses NIN / row TILE_DIM-1;
  - NORTH uses SIN / row 0.
- **Edge outputs** are continuous views of the boundary cell registers. There is no combinational path from any *IN port to any *OUT port.
- **Handshake rules:**
  - busy=1 in SHIFT and DONE.
  - start while busy=1 is ignored.
  - load_en while busy=1 is ignored (cells belong to the shifter).
- **Readback:** rd_data is valid in all states.
- **Arithmetic:** none on data; the counter is an unsigned CNT_W-bit down-counter and never wraps below 0.

## Timing
- **Reset values:** all cells 0, state IDLE, busy 0, done 0, rd_data 0. Every *OUT is 0.
- **Reset mid-run:** takes effect on the next edge. The run is abandoned with no done pulse.
- **Run timing:** start at edge T with steps=N≥1:
  - busy rises after T;
  - shifts occur at edges T+1 … T+N;
  - done is high for the cycle after edge T+N;
  - busy falls after edge T+N+1.
- **steps=0:** done is high for the cycle after T, with zero shifts.
- **Back-to-back runs:** a start sampled in the cycle after done (IDLE) is accepted. Minimum run-to-run spacing is N+2 cycles.
- **Edge inputs** are sampled at each shift edge and need not be held otherwise.
- **Load:** takes effect at the edge where load_en=1. rd_data reflects the address at edge T, one cycle later.
- **Read/write collision:** load and read of the same cell in the same cycle returns the old value.

## Configuration
- **TILE_MESH_STALL_EN**
  - Defined: adds input port `stall` (1 bit).
    - stall=1 in SHIFT freezes cells and counter for that cycle.
    - Edge inputs are not sampled while stalled.
    - Stall in IDLE/DONE has no effect.
  - Undefined: no `stall` port; SHIFT never pauses.

## Structure
- **Package tile_mesh_pkg:**
  - dir encodings (DIR_EAST … DIR_NORTH);
  - mode encodings (MODE_EDGE_IN, MODE_WRAP, MODE_ZERO);
  - state enum (ST_IDLE, ST_SHIFT, ST_DONE).
- **Sub-module tile_mesh_cell:**
  - one DATA_W register;
  - a 4-way neighbour mux selected by dir;
  - load and shift enables.
- **Top level** holds the FSM, the counter, and the boundary-source muxing per mode.

## Test plan
- **Load/readback:** reset, load a 2x2 array with 0x11, 0x22, 0x33, 0x44 → rd_data returns each value one cycle after its address; EOUT = {0x44, 0x22}.
- **EAST edge-in:** EAST, EDGE_IN, steps=1, WIN lanes 0xA0/0xB0 → row0 = {0xA0, 0x11}, row1 = {0xB0, 0x33}; done exactly 2 cycles after start.
- **NORTH wrap:** NORTH, WRAP, steps=2 on the 2x2 array → array unchanged; busy high 3 cycles; done single pulse.
- **steps=0 and busy ignores:** steps=0 → done the next cycle, array unchanged; start and load_en while busy → ignored.
- **Reset mid-run:** reset mid-run with steps=5 → all cells 0, IDLE, no done pulse.
- **Stall (with TILE_MESH_STALL_EN):** stall held for 2 cycles during steps=3 ZERO WEST → done delayed by 2 cycles; array all zero.

Source files
------------

// File: rtl/tile_mesh_pkg.sv
// ============================================================================
// tile_mesh_pkg : direction, boundary-mode and FSM state encodings for the mesh
// Rev 1.0
// ============================================================================
`default_nettype none

package tile_mesh_pkg;

  typedef enum logic [1:0] {
    DIR_EAST  = 2'd0,
    DIR_WEST  = 2'd1,
    DIR_SOUTH = 2'd2,
    DIR_NORTH = 2'd3
  } dir_e;

  // Code 3 is reserved and behaves as MODE_ZERO.
  typedef enum logic [1:0] {
    MODE_EDGE_IN = 2'd0,
    MODE_WRAP    = 2'd1,
    MODE_ZERO    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tile_shift_mesh_if.sv
// ============================================================================
// tile_shift_mesh_if : run-control handshake and host load/readback port
// Rev 1.0
// ============================================================================
`default_nettype none

interface tile_shift_mesh_if #(
  parameter int TILE_DIM = 2,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 8
);
  localparam int AW = $clog2(TILE_DIM);

  logic              start;
  logic [1:0]        dir;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  steps;
  logic              busy;
  logic              done;
  logic              load_en;
  logic [AW-1:0]     load_row;
  logic [AW-1:0]     load_col;
  logic [DATA_W-1:0] load_data;
  logic [AW-1:0]     rd_row;
  logic [AW-1:0]     rd_col;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output start, dir, mode, steps, load_en, load_row, load_col, load_data, rd_row, rd_col,
    input  busy, done, rd_data
  );

  modport slave (
    input  start, dir, mode, steps, load_en, load_row, load_col, load_data, rd_row, rd_col,
    output busy, done, rd_data
  );

endinterface

`default_nettype wire

// File: rtl/tile_mesh_cell.sv
// ============================================================================
// tile_mesh_cell : one mesh register with a direction-selected neighbour mux
// Rev 1.0
// ============================================================================
`default_nettype none

module tile_mesh_cell
  import tile_mesh_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en_i,
  input  dir_e              dir_i,
  input  logic [DATA_W-1:0] from_w_i,
  input  logic [DATA_W-1:0] from_e_i,
  input  logic [DATA_W-1:0] from_n_i,
  input  logic [DATA_W-1:0] from_s_i,
  input  logic              load_en_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] w_nbr;

  // Data moves toward dir, so an EAST shift pulls from the western neighbour.
  always_comb begin
    w_nbr = from_s_i;
    case (dir_i)
      DIR_EAST:  w_nbr = from_w_i;
      DIR_WEST:  w_nbr = from_e_i;
      DIR_SOUTH: w_nbr = from_n_i;
      default:   w_nbr = from_s_i;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (shift_en_i) begin
      data_d = w_nbr;
    end else if (load_en_i) begin
      data_d = load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/tile_shift_mesh.sv
// ============================================================================
// tile_shift_mesh : TILE_DIM x TILE_DIM shift fabric with step-counted runs
// Optional: TILE_MESH_STALL_EN adds a stall input that pauses SHIFT.  Rev 1.0
// ============================================================================
`default_nettype none

module tile_shift_mesh
  import tile_mesh_pkg::*;
#(
  parameter int TILE_DIM = 2,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef TILE_MESH_STALL_EN
  input  logic                       stall,
`endif
  tile_shift_mesh_if.slave           bus,
  input  logic [TILE_DIM*DATA_W-1:0] WIN,
  input  logic [TILE_DIM*DATA_W-1:0] EIN,
  input  logic [TILE_DIM*DATA_W-1:0] NIN,
  input  logic [TILE_DIM*DATA_W-1:0] SIN,
  output logic [TILE_DIM*DATA_W-1:0] WOUT,
  output logic [TILE_DIM*DATA_W-1:0] EOUT,
  output logic [TILE_DIM*DATA_W-1:0] NOUT,
  output logic [TILE_DIM*DATA_W-1:0] SOUT
);

  localparam int AW   = $clog2(TILE_DIM);
  localparam int LAST = TILE_DIM - 1;

  state_e            state_q;
  dir_e              dir_q;
  mode_e             mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              w_stall;
  logic              w_shift_en;
  logic              w_load_ok;

  logic [DATA_W-1:0] w_cell  [TILE_DIM][TILE_DIM];
  logic [DATA_W-1:0] w_src_w [TILE_DIM];
  logic [DATA_W-1:0] w_src_e [TILE_DIM];
  logic [DATA_W-1:0] w_src_n [TILE_DIM];
  logic [DATA_W-1:0] w_src_s [TILE_DIM];

`ifdef TILE_MESH_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_shift_en = (state_q == ST_SHIFT) && !w_stall;
  assign w_load_ok  = bus.load_en && (state_q == ST_IDLE);
  assign cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

  // Boundary sources: the value entering the mesh on the side opposite dir.
  for (genvar i = 0; i < TILE_DIM; i++) begin : g_bnd
    assign w_src_w[i] = (mode_q == MODE_EDGE_IN) ? WIN[i*DATA_W +: DATA_W] :
                        (mode_q == MODE_WRAP)    ? w_cell[i][LAST] : '0;
    assign w_src_e[i] = (mode_q == MODE_EDGE_IN) ? EIN[i*DATA_W +: DATA_W] :
                        (mode_q == MODE_WRAP)    ? w_cell[i][0] : '0;
    assign w_src_n[i] = (mode_q == MODE_EDGE_IN) ? NIN[i*DATA_W +: DATA_W] :
                        (mode_q == MODE_WRAP)    ? w_cell[LAST][i] : '0;
    assign w_src_s[i] = (mode_q == MODE_EDGE_IN) ? SIN[i*DATA_W +: DATA_W] :
                        (mode_q == MODE_WRAP)    ? w_cell[0][i] : '0;

    assign WOUT[i*DATA_W +: DATA_W] = w_cell[i][0];
    assign EOUT[i*DATA_W +: DATA_W] = w_cell[i][LAST];
    assign NOUT[i*DATA_W +: DATA_W] = w_cell[0][i];
    assign SOUT[i*DATA_W +: DATA_W] = w_cell[LAST][i];
  end

  for (genvar r = 0; r < TILE_DIM; r++) begin : g_row
    for (genvar c = 0; c < TILE_DIM; c++) begin : g_col
      logic [DATA_W-1:0] w_from_w;
      logic [DATA_W-1:0] w_from_e;
      logic [DATA_W-1:0] w_from_n;
      logic [DATA_W-1:0] w_from_s;

      if (c == 0) begin : g_w_edge
        assign w_from_w = w_src_w[r];
      end else begin : g_w_int
        assign w_from_w = w_cell[r][c-1];
      end

      if (c == LAST) begin : g_e_edge
        assign w_from_e = w_src_e[r];
      end else begin : g_e_int
        assign w_from_e = w_cell[r][c+1];
      end

      if (r == 0) begin : g_n_edge
        assign w_from_n = w_src_n[c];
      end else begin : g_n_int
        assign w_from_n = w_cell[r-1][c];
      end

      if (r == LAST) begin : g_s_edge
        assign w_from_s = w_src_s[c];
      end else begin : g_s_int
        assign w_from_s = w_cell[r+1][c];
      end

      tile_mesh_cell #(
        .DATA_W (DATA_W)
      ) u_cell (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (w_shift_en),
        .dir_i       (dir_q),
        .from_w_i    (w_from_w),
        .from_e_i    (w_from_e),
        .from_n_i    (w_from_n),
        .from_s_i    (w_from_s),
        .load_en_i   (w_load_ok && (bus.load_row == AW'(r)) && (bus.load_col == AW'(c))),
        .load_data_i (bus.load_data),
        .data_o      (w_cell[r][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_EAST;
      mode_q  <= MODE_EDGE_IN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            dir_q  <= dir_e'(bus.dir);
            mode_q <= mode_e'(bus.mode);
            cnt_q  <= bus.steps;
            busy_q <= 1'b1;
            if (bus.steps == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (!w_stall) begin
            cnt_q <= cnt_d;
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read port sees pre-edge contents, so a same-cycle load returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= w_cell[bus.rd_row][bus.rd_col];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_shift_mesh.sv
// ============================================================================
// tb_tile_shift_mesh : randomized runs against a queue-based line-shift model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tile_shift_mesh;
  import tile_mesh_pkg::*;

  localparam int D  = 2;
  localparam int W  = 8;
  localparam int C  = 8;
  localparam int AW = $clog2(D);
  localparam int LW = D * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tile_shift_mesh_if #(.TILE_DIM(D), .DATA_W(W), .CNT_W(C)) bus ();

  logic [LW-1:0] win, ein, nin, sin;
  logic [LW-1:0] wout, eout, nout, sout;
`ifdef TILE_MESH_STALL_EN
  logic stall;
`endif

  tile_shift_mesh #(.TILE_DIM(D), .DATA_W(W), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef TILE_MESH_STALL_EN
    .stall (stall),
`endif
    .bus   (bus),
    .WIN   (win),
    .EIN   (ein),
    .NIN   (nin),
    .SIN   (sin),
    .WOUT  (wout),
    .EOUT  (eout),
    .NOUT  (nout),
    .SOUT  (sout)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] m [D][D];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane(input logic [LW-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [W-1:0] bsrc(input int md, input logic [W-1:0] ev, input logic [W-1:0] wv);
    if (md == 0) return ev;
    if (md == 1) return wv;
    return '0;
  endfunction

  // Each row (EAST/WEST) or column (SOUTH/NORTH) is a queue: insert the
  // boundary value at the upstream end and drop the element falling off.
  task automatic model_shift(input int d, input int md);
    for (int k = 0; k < D; k++) begin
      logic [W-1:0] q [$];
      logic [W-1:0] src;
      q = {};
      for (int j = 0; j < D; j++) q.push_back((d < 2) ? m[k][j] : m[j][k]);
      case (d)
        0:       src = bsrc(md, lane(win, k), q[D-1]);
        1:       src = bsrc(md, lane(ein, k), q[0]);
        2:       src = bsrc(md, lane(nin, k), q[D-1]);
        default: src = bsrc(md, lane(sin, k), q[0]);
      endcase
      if (d == 0 || d == 2) begin
        q.push_front(src);
        void'(q.pop_back());
      end else begin
        q.push_back(src);
        void'(q.pop_front());
      end
      for (int j = 0; j < D; j++) begin
        if (d < 2) m[k][j] = q[j];
        else       m[j][k] = q[j];
      end
    end
  endtask

  task automatic rand_edges(input bit fixed);
    win = fixed ? LW'(16'hB0A0) : LW'($urandom);
    ein = LW'($urandom);
    nin = LW'($urandom);
    sin = LW'($urandom);
  endtask

  task automatic check_all(input string tag);
    logic [LW-1:0] ew, ee, en, es;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        bus.rd_row = AW'(r);
        bus.rd_col = AW'(c);
        step();
        chk($sformatf("%s rd[%0d][%0d]", tag, r, c), bus.rd_data, m[r][c]);
      end
    end
    for (int i = 0; i < D; i++) begin
      ew[i*W +: W] = m[i][0];
      ee[i*W +: W] = m[i][D-1];
      en[i*W +: W] = m[0][i];
      es[i*W +: W] = m[D-1][i];
    end
    chk({tag, " wout"}, wout, ew);
    chk({tag, " eout"}, eout, ee);
    chk({tag, " nout"}, nout, en);
    chk({tag, " sout"}, sout, es);
  endtask

  task automatic load(input int r, input int c, input logic [W-1:0] v);
    bus.load_en   = 1'b1;
    bus.load_row  = AW'(r);
    bus.load_col  = AW'(c);
    bus.load_data = v;
    step();
    bus.load_en = 1'b0;
    m[r][c] = v;
  endtask

  task automatic run(input int d, input int md, input int n, input bit fixed,
                     input bit disturb, input int stall_at, input int stall_len);
    int busy_cnt = 0, done_cnt = 0, done_at = -1, shifts = 0, exp_done_at;
    int cyc, budget;
    bit st, will;
    budget      = n + stall_len + 8;
    exp_done_at = (n == 0) ? 0 : -1;
    bus.dir   = 2'(d);
    bus.mode  = 2'(md);
    bus.steps = C'(n);
    bus.start = 1'b1;
    rand_edges(fixed);
    step();
    bus.start = 1'b0;
    for (cyc = 0; cyc < budget; cyc++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (!bus.busy) break;
      st = (shifts < n) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
`ifdef TILE_MESH_STALL_EN
      stall = st;
`endif
      if (disturb && cyc == 0) begin
        bus.start     = 1'b1;
        bus.dir       = 2'((d + 1) % 4);
        bus.steps     = C'(7);
        bus.load_en   = 1'b1;
        bus.load_row  = '0;
        bus.load_col  = '0;
        bus.load_data = ~m[0][0];
      end else begin
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
      end
      rand_edges(fixed);
      will = (shifts < n) && !st;
      step();
      if (will) begin
        model_shift(d, md);
        shifts++;
        if (shifts == n) exp_done_at = cyc + 1;
      end
    end
`ifdef TILE_MESH_STALL_EN
    stall = 1'b0;
`endif
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    chk($sformatf("run d%0d m%0d n%0d timeout", d, md, n), (cyc >= budget), 0);
    chk($sformatf("run d%0d m%0d n%0d done_at", d, md, n), done_at, exp_done_at);
    chk($sformatf("run d%0d m%0d n%0d done_cnt", d, md, n), done_cnt, 1);
    chk($sformatf("run d%0d m%0d n%0d busy_cnt", d, md, n), busy_cnt, exp_done_at + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    bus.start = 1'b0; bus.dir = '0; bus.mode = '0; bus.steps = '0;
    bus.load_en = 1'b0; bus.load_row = '0; bus.load_col = '0; bus.load_data = '0;
    bus.rd_row = '0; bus.rd_col = '0;
`ifdef TILE_MESH_STALL_EN
    stall = 1'b0;
`endif
    rand_edges(1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int r = 0; r < D; r++) for (int c = 0; c < D; c++) m[r][c] = '0;

    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst rd_data", bus.rd_data, 0);
    chk("rst wout", wout, 0);
    chk("rst eout", eout, 0);
    chk("rst nout", nout, 0);
    chk("rst sout", sout, 0);

    load(0, 0, 8'h11);
    load(0, 1, 8'h22);
    load(1, 0, 8'h33);
    load(1, 1, 8'h44);
    check_all("load");
    chk("load eout const", eout, 16'h4422);

    run(0, 0, 1, 1'b1, 1'b0, 0, 0);
    check_all("east");
    chk("east wout const", wout, 16'hB0A0);
    chk("east eout const", eout, 16'h3311);

    run(3, 1, 2, 1'b0, 1'b0, 0, 0);
    check_all("north");
    chk("north nout const", nout, 16'h11A0);

    run(2, 0, 0, 1'b0, 1'b1, 0, 0);
    check_all("steps0");

    run(1, 0, 3, 1'b0, 1'b1, 0, 0);
    check_all("disturb");

    // Same-cycle load and read of one cell: read returns the prior contents.
    bus.rd_row = AW'(0);
    bus.rd_col = AW'(1);
    bus.load_en = 1'b1;
    bus.load_row = AW'(0);
    bus.load_col = AW'(1);
    bus.load_data = ~m[0][1];
    step();
    bus.load_en = 1'b0;
    chk("collide old", bus.rd_data, m[0][1]);
    m[0][1] = ~m[0][1];
    step();
    chk("collide new", bus.rd_data, m[0][1]);

    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        load($urandom_range(0, D - 1), $urandom_range(0, D - 1), W'($urandom));
      run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
          1'b0, 1'($urandom_range(0, 1)), 0, 0);
      check_all($sformatf("rand%0d", t));
    end

`ifdef TILE_MESH_STALL_EN
    run(1, 2, 3, 1'b0, 1'b0, 1, 2);
    check_all("stall");
    chk("stall zero", {wout, eout}, 0);
`endif

    load(0, 0, 8'h5A);
    bus.dir = 2'(0); bus.mode = 2'(1); bus.steps = C'(5); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 0; r < D; r++) for (int c = 0; c < D; c++) m[r][c] = '0;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.done) dn++;
    end
    chk("midrst no done", dn, 0);
    check_all("midrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
